// File: rtl/dm_ctrl_pkg.sv
// Shared encodings, FSM states and defaults for the data-memory access controller.
package dm_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned MEM_BYTES_DEF = 12288;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StRmw,
        StResp
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Little-endian lane logic: sub-word load extract/extend and sub-word store merge.
module dm_lane_unit
    import dm_ctrl_pkg::*;
(
    input  logic [31:0] load_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] mask;

    assign shamt   = {off_i, 3'b000};
    assign shifted = load_word_i >> shamt;

    always_comb begin
        rdata_o   = load_word_i;
        lane_mask = 32'hFFFF_FFFF;
        case (size_i)
            SZ_BYTE: begin
                rdata_o   = uns_i ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                rdata_o   = uns_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF;
            end
            default: begin
                rdata_o   = load_word_i;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign mask     = lane_mask << shamt;
    assign merged_o = (old_word_i & ~mask) | ((wdata_i << shamt) & mask);

endmodule

// File: rtl/dm_access_ctrl.sv
// Two-port round-robin sequencer in front of a word-only data memory; adds sub-word
// access, alignment/range checking and read-modify-write for sub-word stores.
module dm_access_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    input  logic              uns0,
    input  logic              uns1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_din,
    output logic              m_we,
    input  logic [31:0]       m_dout
);

    state_e            state_q, state_d;
    logic              prio_q, prio_d;   // 1: port 1 wins a tie
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       mbuf_q, mbuf_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;

    logic              sel;
    logic [31:0]       last_byte;
    logic              acc_err;
    logic [31:0]       lane_rdata;
    logic [31:0]       lane_merged;

    dm_lane_unit u_lane (
        .load_word_i (m_dout),
        .old_word_i  (mbuf_q),
        .wdata_i     (wdata_q),
        .off_i       (addr_q[1:0]),
        .size_i      (size_q),
        .uns_i       (uns_q),
        .rdata_o     (lane_rdata),
        .merged_o    (lane_merged)
    );

    assign sel       = (req0 & req1) ? prio_q : req1;
    assign last_byte = 32'(addr_q) + 32'(size_bytes(size_q)) - 32'd1;
    assign acc_err   = (size_q == 2'b11)
                     | ((size_q == SZ_HALF) & addr_q[0])
                     | ((size_q == SZ_WORD) & (|addr_q[1:0]))
                     | (last_byte >= MEM_BYTES);

    assign m_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign err0   = ack0 & err_q;
    assign err1   = ack1 & err_q;

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        mbuf_d   = mbuf_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        m_we     = 1'b0;
        m_din    = 32'h0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    gnt_d   = sel;
                    prio_d  = ~sel;
                    we_d    = sel ? we1 : we0;
                    size_d  = sel ? size1 : size0;
                    uns_d   = sel ? uns1 : uns0;
                    addr_d  = sel ? addr1 : addr0;
                    wdata_d = sel ? wdata1 : wdata0;
                    err_d   = 1'b0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (acc_err) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (!we_q) begin
                    if (gnt_q) rdata1_d = lane_rdata;
                    else       rdata0_d = lane_rdata;
                    state_d = StResp;
                end else if (size_q == SZ_WORD) begin
                    m_we    = 1'b1;
                    m_din   = wdata_q;
                    state_d = StResp;
                end else begin
                    mbuf_d  = m_dout;
                    state_d = StRmw;
                end
            end
            StRmw: begin
                m_we    = 1'b1;
                m_din   = lane_merged;
                state_d = StResp;
            end
            StResp: begin
                ack0    = ~gnt_q;
                ack1    = gnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            mbuf_q   <= 32'h0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            mbuf_q   <= mbuf_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a word-wide memory model behind the port.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [1:0]  size0 = 2'b00, size1 = 2'b00;
    logic        uns0 = 1'b0, uns1 = 1'b0;
    logic [13:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [13:0] m_addr;
    logic [31:0] m_din;
    logic        m_we;
    logic [31:0] m_dout;

    logic [31:0] mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] t_rd;
    logic        t_er;
    int          t_cyc;
    int          t_wecnt;
    logic [13:0] t_waddr;
    int          t_other;

    always #5 clk = ~clk;

    assign m_dout = mem[m_addr[13:2]];
    always @(posedge clk) if (m_we) mem[m_addr[13:2]] <= m_din;

    dm_access_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .size0  (size0),
        .size1  (size1),
        .uns0   (uns0),
        .uns1   (uns1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .ack0   (ack0),
        .ack1   (ack1),
        .err0   (err0),
        .err1   (err1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .m_addr (m_addr),
        .m_din  (m_din),
        .m_we   (m_we),
        .m_dout (m_dout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request in an IDLE cycle and wait for its ack; cycle 1 is the request cycle.
    task automatic do_txn(input int port, input logic we, input logic [1:0] size, input logic uns,
                          input logic [13:0] addr, input logic [31:0] wdata);
        logic got;
        @(negedge clk);
        if (port == 0) begin
            req0 = 1'b1; we0 = we; size0 = size; uns0 = uns; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = 1'b1; we1 = we; size1 = size; uns1 = uns; addr1 = addr; wdata1 = wdata;
        end
        got = 1'b0; t_cyc = 1; t_wecnt = 0; t_waddr = '0; t_rd = '0; t_er = 1'b0; t_other = 0;
        while (!got && t_cyc < 12) begin
            @(posedge clk);
            #1;
            t_cyc++;
            if (m_we) begin
                t_wecnt++;
                t_waddr = m_addr;
            end
            if ((port == 0 && ack1) || (port == 1 && ack0)) t_other++;
            if (port == 0 && ack0) begin
                got = 1'b1; t_rd = rdata0; t_er = err0;
            end else if (port == 1 && ack1) begin
                got = 1'b1; t_rd = rdata1; t_er = err1;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check_eq("txn_ack_seen", 32'(got), 32'd1);
        @(posedge clk);
    endtask

    task automatic expect_err(input string tag, input logic [1:0] size, input logic [13:0] addr);
        do_txn(0, 1'b1, size, 1'b0, addr, 32'hFFFF_FFFF);
        check_eq({tag, "_err"}, 32'(t_er), 32'd1);
        check_eq({tag, "_nowe"}, 32'(t_wecnt), 32'd0);
        check_eq({tag, "_lat"}, 32'(t_cyc), 32'd3);
    endtask

    initial begin
        int seq [4];
        int n_ack;
        int both;
        logic first_port;
        logic got;

        #1;
        check_eq("rst_ctrl", {27'h0, ack0, ack1, err0, err1, m_we}, 32'h0);
        check_eq("rst_rdata0", rdata0, 32'h0);
        check_eq("rst_rdata1", rdata1, 32'h0);
        check_eq("rst_maddr", 32'(m_addr), 32'h0);
        check_eq("rst_mdin", m_din, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store / load on port 0
        do_txn(0, 1'b1, 2'b10, 1'b0, 14'h0010, 32'hDEAD_BEEF);
        check_eq("sw_lat", 32'(t_cyc), 32'd3);
        check_eq("sw_we_cnt", 32'(t_wecnt), 32'd1);
        check_eq("sw_we_addr", 32'(t_waddr), 32'h10);
        check_eq("sw_mem", mem[4], 32'hDEAD_BEEF);
        check_eq("sw_err", 32'(t_er), 32'd0);
        do_txn(0, 1'b0, 2'b10, 1'b0, 14'h0010, 32'h0);
        check_eq("lw_data", t_rd, 32'hDEAD_BEEF);
        check_eq("lw_err", 32'(t_er), 32'd0);
        check_eq("lw_lat", 32'(t_cyc), 32'd3);
        check_eq("lw_nowe", 32'(t_wecnt), 32'd0);

        // Alignment, range and illegal-size errors
        expect_err("sh_mis", 2'b01, 14'h0001);
        expect_err("sw_mis", 2'b10, 14'h0002);
        expect_err("sw_12286", 2'b10, 14'd12286);
        expect_err("sw_12288", 2'b10, 14'd12288);
        expect_err("sz_ill", 2'b11, 14'h0040);
        do_txn(0, 1'b1, 2'b10, 1'b0, 14'd12284, 32'h0102_0304);
        check_eq("sw_top_err", 32'(t_er), 32'd0);
        do_txn(0, 1'b1, 2'b00, 1'b0, 14'd12287, 32'h0000_005A);
        check_eq("sb_top_err", 32'(t_er), 32'd0);
        check_eq("sb_top_lat", 32'(t_cyc), 32'd4);
        check_eq("sb_top_mem", mem[3071], 32'h5A02_0304);

        // Sub-word store and loads on port 1
        do_txn(1, 1'b1, 2'b10, 1'b0, 14'h0020, 32'h1122_3344);
        do_txn(1, 1'b1, 2'b00, 1'b0, 14'h0022, 32'h0000_00AB);
        check_eq("sb_lat", 32'(t_cyc), 32'd4);
        check_eq("sb_we_cnt", 32'(t_wecnt), 32'd1);
        check_eq("sb_mem", mem[8], 32'h11AB_3344);
        check_eq("sb_no_ack0", 32'(t_other), 32'd0);
        do_txn(1, 1'b0, 2'b00, 1'b0, 14'h0022, 32'h0);
        check_eq("lb_data", t_rd, 32'hFFFF_FFAB);
        do_txn(1, 1'b0, 2'b01, 1'b1, 14'h0022, 32'h0);
        check_eq("lhu_data", t_rd, 32'h0000_11AB);

        // Contention: both held, last single grant was port 1
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; uns0 = 1'b0; addr0 = 14'h0010;
        req1 = 1'b1; we1 = 1'b0; size1 = 2'b10; uns1 = 1'b0; addr1 = 14'h0020;
        n_ack = 0;
        both = 0;
        for (int c = 0; c < 30 && n_ack < 4; c++) begin
            @(posedge clk);
            #1;
            if (ack0 && ack1) both++;
            if (ack0) begin seq[n_ack] = 0; n_ack++; end
            else if (ack1) begin seq[n_ack] = 1; n_ack++; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check_eq("rr_count", 32'(n_ack), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < n_ack) check_eq("rr_order", 32'(seq[i]), 32'(i % 2));
        end
        check_eq("rr_no_both", 32'(both), 32'd0);
        check_eq("rr_rdata0", rdata0, 32'hDEAD_BEEF);
        check_eq("rr_rdata1", rdata1, 32'h11AB_3344);
        @(posedge clk);

        // Reset during the RMW cycle of sb 0x0030
        do_txn(0, 1'b1, 2'b10, 1'b0, 14'h0030, 32'h5566_7788);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; size0 = 2'b00; uns0 = 1'b0; addr0 = 14'h0030; wdata0 = 32'hCC;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("rmw_we_hi", 32'(m_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_we_drop", 32'(m_we), 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_no_ack", {30'h0, ack0, ack1}, 32'h0);
        check_eq("rst_mem_keep", mem[12], 32'h5566_7788);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; addr0 = 14'h0030;
        req1 = 1'b1; we1 = 1'b0; size1 = 2'b10; addr1 = 14'h0020;
        got = 1'b0;
        first_port = 1'b1;
        for (int c = 0; c < 8 && !got; c++) begin
            @(posedge clk);
            #1;
            if (ack0 || ack1) begin
                got = 1'b1;
                first_port = ack1;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check_eq("post_rst_ack", 32'(got), 32'd1);
        check_eq("post_rst_port0", 32'(first_port), 32'd0);
        check_eq("post_rst_data", rdata0, 32'h5566_7788);
        @(posedge clk);

        // Request dropped the cycle after grant
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; addr0 = 14'h0010;
        @(negedge clk);
        req0 = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(posedge clk);
            #1;
            if (ack0) got = 1'b1;
        end
        check_eq("drop_ack", 32'(got), 32'd1);
        check_eq("drop_rdata", rdata0, 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
